wb2ahb: RTL and testbench

WB2AHB -- requirements
Module: wb2ahb

---
 rtl/wb2ahb.sv | 209 ++++++++++++++++++++
 tb/tb_wb2ahb.sv | 556 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb2ahb.sv
// Wishbone classic slave bridged onto a single-transfer AHB master.
// One transfer in flight; RETRY/SPLIT responses are reissued up to RETRY_MAX times.
module wb2ahb #(
    parameter logic [3:0] RETRY_MAX = 4'd15
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] adr_i,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    input  logic [3:0]  sel_i,
    input  logic        we_i,
    input  logic        cyc_i,
    input  logic        stb_i,
    output logic        ack_o,
    output logic        err_o,
    output logic        hbusreq,
    input  logic        hgrant,
    output logic [31:0] haddr,
    output logic [1:0]  htrans,
    output logic        hwrite,
    output logic [2:0]  hsize,
    output logic [2:0]  hburst,
    output logic [31:0] hwdata,
    input  logic [31:0] hrdata,
    input  logic        hready,
    input  logic [1:0]  hresp
);

    localparam logic [1:0] TR_IDLE    = 2'b00;
    localparam logic [1:0] TR_NONSEQ  = 2'b10;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        ADDR,
        DATA,
        DONE
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic [3:0] retry_q;
    logic [3:0] retry_nx;
    logic       err_q;
    logic       err_nx;
    logic       abort_q;
    logic       abort_nx;
    logic       latch;
    logic       capture;

    logic       sel_ok;
    logic [2:0] sel_size;
    logic [1:0] sel_lo;

    // Only naturally aligned byte, halfword and word lanes are legal.
    always_comb begin
        sel_ok   = 1'b1;
        sel_size = 3'b000;
        sel_lo   = 2'b00;
        case (sel_i)
            4'b1111: begin
                sel_size = 3'b010;
            end
            4'b0011: begin
                sel_size = 3'b001;
            end
            4'b1100: begin
                sel_size = 3'b001;
                sel_lo   = 2'b10;
            end
            4'b0001: begin
                sel_lo = 2'b00;
            end
            4'b0010: begin
                sel_lo = 2'b01;
            end
            4'b0100: begin
                sel_lo = 2'b10;
            end
            4'b1000: begin
                sel_lo = 2'b11;
            end
            default: begin
                sel_ok = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_nx = state;
        retry_nx = retry_q;
        err_nx   = err_q;
        abort_nx = abort_q;
        latch    = 1'b0;
        capture  = 1'b0;
        case (state)
            IDLE: begin
                err_nx   = 1'b0;
                abort_nx = 1'b0;
                if (cyc_i && stb_i) begin
                    if (sel_ok) begin
                        latch    = 1'b1;
                        retry_nx = 4'd0;
                        state_nx = REQ;
                    end else begin
                        // Bad lane pattern terminates through DONE as an error.
                        err_nx   = 1'b1;
                        state_nx = DONE;
                    end
                end
            end
            REQ: begin
                if (!cyc_i) begin
                    state_nx = IDLE;
                end else if (hgrant && hready) begin
                    state_nx = ADDR;
                end
            end
            ADDR: begin
                if (!cyc_i) begin
                    abort_nx = 1'b1;
                end
                if (hready) begin
                    state_nx = DATA;
                end
            end
            DATA: begin
                if (!cyc_i) begin
                    abort_nx = 1'b1;
                end
                if (hready) begin
                    // An abandoned cycle still finishes on AHB, result dropped.
                    if (abort_q || !cyc_i) begin
                        state_nx = IDLE;
                    end else begin
                        unique case (hresp)
                            RESP_OKAY: begin
                                capture  = !hwrite;
                                state_nx = DONE;
                            end
                            RESP_ERROR: begin
                                err_nx   = 1'b1;
                                state_nx = DONE;
                            end
                            default: begin
                                if (retry_q < RETRY_MAX) begin
                                    retry_nx = retry_q + 4'd1;
                                    state_nx = REQ;
                                end else begin
                                    err_nx   = 1'b1;
                                    state_nx = DONE;
                                end
                            end
                        endcase
                    end
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= IDLE;
            retry_q <= 4'd0;
            err_q   <= 1'b0;
            abort_q <= 1'b0;
            ack_o   <= 1'b0;
            err_o   <= 1'b0;
            hbusreq <= 1'b0;
            htrans  <= TR_IDLE;
            hburst  <= 3'b000;
            hwrite  <= 1'b0;
            hsize   <= 3'b000;
            haddr   <= 32'd0;
            hwdata  <= 32'd0;
            dat_o   <= 32'd0;
        end else begin
            state   <= state_nx;
            retry_q <= retry_nx;
            err_q   <= err_nx;
            abort_q <= abort_nx;
            ack_o   <= (state_nx == DONE) && !err_nx;
            err_o   <= (state_nx == DONE) && err_nx;
            hbusreq <= (state_nx == REQ) || (state_nx == ADDR);
            htrans  <= (state_nx == ADDR) ? TR_NONSEQ : TR_IDLE;
            hburst  <= 3'b000;
            if (latch) begin
                haddr  <= {adr_i[31:2], sel_lo};
                hsize  <= sel_size;
                hwrite <= we_i;
                hwdata <= dat_i;
            end
            if (capture) begin
                dat_o <= hrdata;
            end
        end
    end

endmodule

// File: tb/tb_wb2ahb.sv
// Self-checking bench for wb2ahb: directed spec scenarios plus
// randomized transfers checked against a behavioural bridge model.
module tb_wb2ahb;

    localparam int RMAX = 15;
    localparam logic [1:0] TR_IDLE    = 2'b00;
    localparam logic [1:0] TR_NONSEQ  = 2'b10;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;
    localparam logic [1:0] RESP_RETRY = 2'b10;
    localparam logic [1:0] RESP_SPLIT = 2'b11;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] adr_i = '0;
    logic [31:0] dat_i = '0;
    logic [31:0] dat_o;
    logic [3:0]  sel_i = '0;
    logic        we_i = 1'b0;
    logic        cyc_i = 1'b0;
    logic        stb_i = 1'b0;
    logic        ack_o;
    logic        err_o;
    logic        hbusreq;
    logic        hgrant = 1'b1;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic [31:0] hrdata = '0;
    logic        hready = 1'b1;
    logic [1:0]  hresp = 2'b00;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] exp_dat = '0;

    wb2ahb dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .adr_i  (adr_i),
        .dat_i  (dat_i),
        .dat_o  (dat_o),
        .sel_i  (sel_i),
        .we_i   (we_i),
        .cyc_i  (cyc_i),
        .stb_i  (stb_i),
        .ack_o  (ack_o),
        .err_o  (err_o),
        .hbusreq(hbusreq),
        .hgrant (hgrant),
        .haddr  (haddr),
        .htrans (htrans),
        .hwrite (hwrite),
        .hsize  (hsize),
        .hburst (hburst),
        .hwdata (hwdata),
        .hrdata (hrdata),
        .hready (hready),
        .hresp  (hresp)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Behavioural model: lane legality, AHB address/size and cycle count.
    function automatic void predict(
        input logic [31:0] adr, input logic [3:0] sel, input int waits,
        input int n_bad, input logic [1:0] fin_resp,
        output bit legal, output logic [31:0] e_haddr,
        output logic [2:0] e_hsize, output int e_lat,
        output int e_ns, output bit e_err);
        int pop;
        int low;
        int att;
        pop = $countones(sel);
        low = 0;
        for (int i = 3; i >= 0; i--) if (sel[i]) low = i;
        legal = 0;
        if (pop == 1 || pop == 2 || pop == 4)
            legal = (low % pop == 0) &&
                    (int'(sel) == (((1 << pop) - 1) << low));
        e_hsize = (pop == 4) ? 3'd2 : (pop == 2) ? 3'd1 : 3'd0;
        e_haddr = {adr[31:2], 2'(low)};
        if (!legal) begin
            e_lat = 1;
            e_ns  = 0;
            e_err = 1;
        end else begin
            att   = (n_bad > RMAX) ? RMAX + 1 : n_bad + 1;
            e_err = (n_bad > RMAX) || (fin_resp == RESP_ERROR);
            e_ns  = att;
            e_lat = 1 + att * (3 + waits);
        end
    endfunction

    // Wishbone master plus AHB slave for one transfer; reports observations.
    task automatic run_xfer(
        input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
        input logic we, input logic [31:0] rdata, input int waits,
        input int n_bad, input logic [1:0] bad_resp,
        input logic [1:0] fin_resp, input int tail,
        output int lat, output int nonseq, output int acks, output int errs,
        output logic [31:0] a_haddr, output logic [2:0] a_hsize,
        output logic a_hwrite, output logic [31:0] a_hwdata,
        output int proto, output bit req_seen);
        int phase;
        int wcnt;
        int attempt;
        int after;
        bit done;
        logic [1:0] cur;
        lat = -1; nonseq = 0; acks = 0; errs = 0; proto = 0;
        a_haddr = '0; a_hsize = '0; a_hwrite = 0; a_hwdata = '0;
        req_seen = 0;
        phase = 0; wcnt = 0; attempt = 0; after = 0; done = 0;
        cur = RESP_OKAY;
        @(negedge clk_i);
        adr_i = adr; dat_i = dat; sel_i = sel; we_i = we;
        cyc_i = 1; stb_i = 1;
        hrdata = rdata; hready = 1; hresp = RESP_OKAY; hgrant = 1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk_i);
            if (hbusreq) req_seen = 1;
            if (ack_o) acks++;
            if (err_o) errs++;
            if ((ack_o && err_o) || hburst != 3'b000 ||
                (htrans != TR_IDLE && htrans != TR_NONSEQ)) proto++;
            if (phase == 1) begin
                if (nonseq == 1 && wcnt == 0) a_hwdata = hwdata;
                if (wcnt < waits) begin
                    hready = 0; hresp = cur; wcnt++;
                end else begin
                    hready = 1; hresp = cur; phase = 2; attempt++;
                end
            end else if (phase == 2) begin
                hresp = RESP_OKAY; phase = 0;
            end
            if (htrans == TR_NONSEQ) begin
                nonseq++;
                if (nonseq == 1) begin
                    a_haddr = haddr; a_hsize = hsize; a_hwrite = hwrite;
                end
                cur = (attempt < n_bad) ? bad_resp : fin_resp;
                phase = 1; wcnt = 0; hready = 1; hresp = RESP_OKAY;
            end
            if (done) begin
                after++;
                if (after >= tail) break;
            end else if (ack_o || err_o) begin
                lat = c + 1;
                done = 1;
                if (tail == 0) break;
                cyc_i = 0; stb_i = 0;
            end
        end
        hready = 1; hresp = RESP_OKAY;
        if (!done) begin
            cyc_i = 0; stb_i = 0;
        end
    endtask

    task automatic test_reset();
        @(posedge clk_i);
        #1;
        vectors++;
        if ({ack_o, err_o, hbusreq, hwrite, htrans, hburst, hsize} !== 13'd0) begin
            miscompares++;
            $display("FAIL reset_ctrl got %b required 0",
                     {ack_o, err_o, hbusreq, hwrite, htrans, hburst, hsize});
        end
        vectors++;
        if ({haddr, hwdata, dat_o} !== 96'd0) begin
            miscompares++;
            $display("FAIL reset_data got %h %h %h required 0", haddr, hwdata, dat_o);
        end
        @(negedge clk_i);
        rst_i = 0;
    endtask

    task automatic test_word_write();
        int lat, ns, ac, er, pr;
        logic [31:0] ha, hd;
        logic [2:0] hs;
        logic hw;
        bit rq;
        run_xfer(32'h1000_0004, 32'hDEAD_BEEF, 4'hF, 1, 32'h0, 0, 0,
                 RESP_RETRY, RESP_OKAY, 3, lat, ns, ac, er, ha, hs, hw, hd, pr, rq);
        vectors++;
        if (ha !== 32'h1000_0004) begin
            miscompares++; $display("FAIL ww_haddr got %h required 10000004", ha);
        end
        vectors++;
        if (hs !== 3'b010) begin
            miscompares++; $display("FAIL ww_hsize got %b required 010", hs);
        end
        vectors++;
        if (hw !== 1'b1) begin
            miscompares++; $display("FAIL ww_hwrite got %b required 1", hw);
        end
        vectors++;
        if (hd !== 32'hDEAD_BEEF) begin
            miscompares++; $display("FAIL ww_hwdata got %h required deadbeef", hd);
        end
        vectors++;
        if (lat !== 4 || ac !== 1 || er !== 0) begin
            miscompares++;
            $display("FAIL ww_ack got lat=%0d ack=%0d err=%0d required 4 1 0", lat, ac, er);
        end
        vectors++;
        if (ns !== 1 || pr !== 0) begin
            miscompares++; $display("FAIL ww_proto got ns=%0d pr=%0d required 1 0", ns, pr);
        end
    endtask

    task automatic test_byte_read();
        int lat, ns, ac, er, pr;
        logic [31:0] ha, hd;
        logic [2:0] hs;
        logic hw;
        bit rq;
        run_xfer(32'h0000_0020, 32'h0, 4'b0100, 0, 32'h00AB_0000, 3, 0,
                 RESP_RETRY, RESP_OKAY, 3, lat, ns, ac, er, ha, hs, hw, hd, pr, rq);
        exp_dat = 32'h00AB_0000;
        vectors++;
        if (ha !== 32'h22 || hs !== 3'b000 || hw !== 1'b0) begin
            miscompares++;
            $display("FAIL br_addr got %h/%b/%b required 22/000/0", ha, hs, hw);
        end
        vectors++;
        if (lat !== 7 || ac !== 1 || er !== 0) begin
            miscompares++;
            $display("FAIL br_ack got lat=%0d ack=%0d err=%0d required 7 1 0", lat, ac, er);
        end
        vectors++;
        if (dat_o !== 32'h00AB_0000) begin
            miscompares++; $display("FAIL br_dat got %h required 00ab0000", dat_o);
        end
    endtask

    task automatic test_error_resp();
        int lat, ns, ac, er, pr;
        logic [31:0] ha, hd;
        logic [2:0] hs;
        logic hw;
        bit rq;
        run_xfer(32'h0000_0040, 32'h0, 4'hF, 0, 32'h1234_5678, 1, 0,
                 RESP_RETRY, RESP_ERROR, 3, lat, ns, ac, er, ha, hs, hw, hd, pr, rq);
        vectors++;
        if (lat !== 5 || ac !== 0 || er !== 1 || pr !== 0) begin
            miscompares++;
            $display("FAIL er_term got lat=%0d ack=%0d err=%0d pr=%0d required 5 0 1 0",
                     lat, ac, er, pr);
        end
        vectors++;
        if (dat_o !== exp_dat) begin
            miscompares++; $display("FAIL er_dat got %h required %h", dat_o, exp_dat);
        end
    endtask

    task automatic test_retry();
        int lat, ns, ac, er, pr;
        logic [31:0] ha, hd;
        logic [2:0] hs;
        logic hw;
        bit rq;
        run_xfer(32'h0000_0080, 32'h0, 4'hF, 0, 32'h5A5A_5A5A, 0, RMAX + 5,
                 RESP_RETRY, RESP_OKAY, 3, lat, ns, ac, er, ha, hs, hw, hd, pr, rq);
        vectors++;
        if (ns !== RMAX + 1 || ac !== 0 || er !== 1 || lat !== 1 + 3 * (RMAX + 1)) begin
            miscompares++;
            $display("FAIL rt_exhaust got ns=%0d ack=%0d err=%0d lat=%0d required %0d 0 1 %0d",
                     ns, ac, er, lat, RMAX + 1, 1 + 3 * (RMAX + 1));
        end
        vectors++;
        if (dat_o !== exp_dat) begin
            miscompares++; $display("FAIL rt_dat got %h required %h", dat_o, exp_dat);
        end
        run_xfer(32'h0000_0084, 32'h0, 4'hF, 0, 32'h0BAD_F00D, 0, 1,
                 RESP_RETRY, RESP_OKAY, 3, lat, ns, ac, er, ha, hs, hw, hd, pr, rq);
        exp_dat = 32'h0BAD_F00D;
        vectors++;
        if (ns !== 2 || ac !== 1 || er !== 0 || lat !== 7) begin
            miscompares++;
            $display("FAIL rt_once got ns=%0d ack=%0d err=%0d lat=%0d required 2 1 0 7",
                     ns, ac, er, lat);
        end
        vectors++;
        if (dat_o !== 32'h0BAD_F00D) begin
            miscompares++; $display("FAIL rt_once_dat got %h required 0badf00d", dat_o);
        end
        run_xfer(32'h0000_0088, 32'h0, 4'hF, 0, 32'h7777_1111, 0, RMAX,
                 RESP_SPLIT, RESP_OKAY, 3, lat, ns, ac, er, ha, hs, hw, hd, pr, rq);
        exp_dat = 32'h7777_1111;
        vectors++;
        if (ns !== RMAX + 1 || ac !== 1 || er !== 0) begin
            miscompares++;
            $display("FAIL rt_edge got ns=%0d ack=%0d err=%0d required %0d 1 0",
                     ns, ac, er, RMAX + 1);
        end
    endtask

    task automatic test_illegal_sel();
        int lat, ns, ac, er, pr;
        logic [31:0] ha, hd;
        logic [2:0] hs;
        logic hw;
        bit rq;
        logic [3:0] pats [2];
        pats[0] = 4'b0101;
        pats[1] = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            run_xfer(32'h0000_0100, 32'h1, pats[i], 1, 32'h0, 0, 0,
                     RESP_RETRY, RESP_OKAY, 3, lat, ns, ac, er, ha, hs, hw, hd, pr, rq);
            vectors++;
            if (lat !== 1 || er !== 1 || ac !== 0 || rq !== 0 || ns !== 0) begin
                miscompares++;
                $display("FAIL ill_%b got lat=%0d err=%0d ack=%0d req=%0d ns=%0d required 1 1 0 0 0",
                         pats[i], lat, er, ac, rq, ns);
            end
        end
    endtask

    task automatic test_abort_req();
        int bad;
        bad = 0;
        @(negedge clk_i);
        hgrant = 0;
        adr_i = 32'h300; sel_i = 4'hF; we_i = 0; cyc_i = 1; stb_i = 1;
        repeat (3) @(negedge clk_i);
        vectors++;
        if (hbusreq !== 1'b1 || htrans !== TR_IDLE) begin
            miscompares++;
            $display("FAIL ar_req got hbusreq=%b htrans=%b required 1 00", hbusreq, htrans);
        end
        cyc_i = 0; stb_i = 0;
        @(negedge clk_i);
        vectors++;
        if (hbusreq !== 1'b0) begin
            miscompares++; $display("FAIL ar_drop got hbusreq=%b required 0", hbusreq);
        end
        hgrant = 1;
        repeat (5) begin
            @(negedge clk_i);
            if (ack_o || err_o || hbusreq || htrans != TR_IDLE) bad++;
        end
        vectors++;
        if (bad !== 0) begin
            miscompares++; $display("FAIL ar_quiet got %0d bad cycles required 0", bad);
        end
    endtask

    task automatic test_abort_xfer(input bit in_data);
        int acks, errs, ns, k;
        bit seen;
        acks = 0; errs = 0; ns = 0; k = 0; seen = 0;
        @(negedge clk_i);
        adr_i = 32'h400; sel_i = 4'hF; we_i = 0; cyc_i = 1; stb_i = 1;
        hrdata = 32'hFEED_0001; hready = 1; hresp = RESP_OKAY; hgrant = 1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_i);
            if (ack_o) acks++;
            if (err_o) errs++;
            if (seen) k++;
            if (htrans == TR_NONSEQ) begin
                ns++;
                seen = 1;
                if (!in_data) begin
                    cyc_i = 0; stb_i = 0;
                end
            end
            if (k == 1) begin
                hready = 0;
                if (in_data) begin
                    cyc_i = 0; stb_i = 0;
                end
            end else begin
                hready = 1;
            end
        end
        vectors++;
        if (ns !== 1 || acks !== 0 || errs !== 0) begin
            miscompares++;
            $display("FAIL ab%0d_term got ns=%0d ack=%0d err=%0d required 1 0 0",
                     in_data, ns, acks, errs);
        end
        vectors++;
        if (dat_o !== exp_dat || hbusreq !== 1'b0) begin
            miscompares++;
            $display("FAIL ab%0d_idle got dat=%h req=%b required %h 0",
                     in_data, dat_o, hbusreq, exp_dat);
        end
    endtask

    task automatic test_reset_mid();
        int lat, ns, ac, er, pr, bad;
        logic [31:0] ha, hd;
        logic [2:0] hs;
        logic hw;
        bit rq;
        bit found;
        found = 0; bad = 0;
        @(negedge clk_i);
        adr_i = 32'h5555_0008; dat_i = 32'hCAFE_F00D; sel_i = 4'hF; we_i = 1;
        cyc_i = 1; stb_i = 1; hready = 1; hgrant = 1; hresp = RESP_OKAY;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_i);
            if (htrans == TR_NONSEQ) begin
                found = 1;
                break;
            end
        end
        vectors++;
        if (!found) begin
            miscompares++; $display("FAIL rm_addr got no NONSEQ required one");
        end
        @(negedge clk_i);
        hready = 0;
        #2 rst_i = 1;
        #1;
        vectors++;
        if ({ack_o, err_o, hbusreq, hwrite, htrans, hburst, hsize} !== 13'd0) begin
            miscompares++;
            $display("FAIL rm_ctrl got %b required 0",
                     {ack_o, err_o, hbusreq, hwrite, htrans, hburst, hsize});
        end
        vectors++;
        if ({haddr, hwdata, dat_o} !== 96'd0) begin
            miscompares++;
            $display("FAIL rm_data got %h %h %h required 0", haddr, hwdata, dat_o);
        end
        cyc_i = 0; stb_i = 0; hready = 1;
        @(negedge clk_i);
        rst_i = 0;
        exp_dat = 32'h0;
        repeat (4) begin
            @(negedge clk_i);
            if (ack_o || err_o || hbusreq) bad++;
        end
        vectors++;
        if (bad !== 0) begin
            miscompares++; $display("FAIL rm_quiet got %0d bad cycles required 0", bad);
        end
        run_xfer(32'h0000_0600, 32'h0, 4'b0011, 0, 32'h0000_BEEF, 0, 0,
                 RESP_RETRY, RESP_OKAY, 3, lat, ns, ac, er, ha, hs, hw, hd, pr, rq);
        exp_dat = 32'h0000_BEEF;
        vectors++;
        if (lat !== 4 || ac !== 1 || dat_o !== 32'h0000_BEEF || ha !== 32'h600) begin
            miscompares++;
            $display("FAIL rm_after got lat=%0d ack=%0d dat=%h addr=%h required 4 1 0000beef 600",
                     lat, ac, dat_o, ha);
        end
    endtask

    task automatic test_back_to_back();
        int lat, ns, ac, er, pr;
        logic [31:0] ha, hd;
        logic [2:0] hs;
        logic hw;
        bit rq;
        run_xfer(32'h0000_0700, 32'h1111_2222, 4'hF, 1, 32'h0, 0, 0,
                 RESP_RETRY, RESP_OKAY, 0, lat, ns, ac, er, ha, hs, hw, hd, pr, rq);
        run_xfer(32'h0000_0704, 32'h0, 4'b1000, 0, 32'hAA00_0000, 0, 0,
                 RESP_RETRY, RESP_OKAY, 3, lat, ns, ac, er, ha, hs, hw, hd, pr, rq);
        exp_dat = 32'hAA00_0000;
        vectors++;
        if (lat !== 4 || ac !== 1 || ns !== 1 || ha !== 32'h707) begin
            miscompares++;
            $display("FAIL b2b got lat=%0d ack=%0d ns=%0d addr=%h required 4 1 1 707",
                     lat, ac, ns, ha);
        end
    endtask

    task automatic test_random();
        int lat, ns, ac, er, pr;
        logic [31:0] ha, hd;
        logic [2:0] hs;
        logic hw;
        bit rq;
        logic [31:0] adr, dat, rd;
        logic [3:0] sel;
        logic we;
        logic [1:0] bresp, fresp;
        int waits, nbad, tail;
        bit legal, e_err;
        logic [31:0] e_ha;
        logic [2:0] e_hs;
        int e_lat, e_ns;
        for (int it = 0; it < 60; it++) begin
            adr = $urandom; dat = $urandom; rd = $urandom;
            sel = 4'($urandom_range(0, 15));
            we = 1'($urandom_range(0, 1));
            waits = $urandom_range(0, 2);
            nbad = ($urandom_range(0, 9) == 0) ? RMAX + 1 : $urandom_range(0, 2);
            bresp = ($urandom_range(0, 1) == 1) ? RESP_SPLIT : RESP_RETRY;
            fresp = ($urandom_range(0, 3) == 0) ? RESP_ERROR : RESP_OKAY;
            tail = $urandom_range(0, 2);
            predict(adr, sel, waits, nbad, fresp, legal, e_ha, e_hs, e_lat, e_ns, e_err);
            run_xfer(adr, dat, sel, we, rd, waits, nbad, bresp, fresp, tail,
                     lat, ns, ac, er, ha, hs, hw, hd, pr, rq);
            if (legal && !e_err && !we) exp_dat = rd;
            vectors++;
            if (lat !== e_lat || ns !== e_ns || ac !== int'(!e_err) ||
                er !== int'(e_err) || pr !== 0 || rq !== legal) begin
                miscompares++;
                $display("FAIL rnd%0d_flow got lat=%0d ns=%0d ack=%0d err=%0d pr=%0d req=%0d required %0d %0d %0d %0d 0 %0d",
                         it, lat, ns, ac, er, pr, rq, e_lat, e_ns, !e_err, e_err, legal);
            end
            vectors++;
            if (dat_o !== exp_dat) begin
                miscompares++;
                $display("FAIL rnd%0d_dat got %h required %h", it, dat_o, exp_dat);
            end
            if (legal) begin
                vectors++;
                if (ha !== e_ha || hs !== e_hs || hw !== we) begin
                    miscompares++;
                    $display("FAIL rnd%0d_addr got %h/%b/%b required %h/%b/%b",
                             it, ha, hs, hw, e_ha, e_hs, we);
                end
                if (we) begin
                    vectors++;
                    if (hd !== dat) begin
                        miscompares++;
                        $display("FAIL rnd%0d_wdata got %h required %h", it, hd, dat);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_word_write();
        test_byte_read();
        test_error_resp();
        test_retry();
        test_illegal_sel();
        test_abort_req();
        test_abort_xfer(1'b0);
        test_abort_xfer(1'b1);
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
